// File: rtl/mm_pkg.sv
// Shared types and constants for the matrix-multiplier input loader.
package mm_pkg;

  typedef enum logic [1:0] {
    FILL      = 2'd0,
    START     = 2'd1,
    STREAM    = 2'd2,
    WAIT_DONE = 2'd3
  } mm_ld_state_t;

  localparam int DW_DEFAULT  = 8;
  localparam int FRAME_CNT_W = 8;

endpackage

// File: rtl/mm_elem_buf.sv
// Frame element store: one synchronous write port, one combinational read port.
module mm_elem_buf
  import mm_pkg::*;
#(
  parameter int DW    = DW_DEFAULT,
  parameter int DEPTH = 32,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data
);

  logic [DW-1:0] mem [DEPTH];

  // NOTE: the array is deliberately not reset; every entry is rewritten by the
  // FILL phase before it is read, so a reset would only cost flops and routing.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/mm_input_loader.sv
// Buffers one A+B operand frame, then starts the multiplier and streams the
// frame out back-to-back, holding off new input until the multiplier is done.
module mm_input_loader
  import mm_pkg::*;
#(
  parameter int DW  = DW_DEFAULT,
  parameter int DIM = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [DW-1:0]          in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic                   mm_start,
  output logic [DW-1:0]          mm_data,
  output logic                   mm_valid,
  input  logic                   mm_done,
  output logic                   busy,
  output logic [FRAME_CNT_W-1:0] frame_cnt,
  output logic                   proto_err
);

  localparam int N_ELEM = 2 * DIM * DIM;
  localparam int AW     = $clog2(N_ELEM);
  localparam logic [AW-1:0] LAST = AW'(N_ELEM - 1);

  mm_ld_state_t           state, state_d;
  logic [AW-1:0]          wptr, wptr_d, rptr, rptr_d, rd_addr;
  logic [FRAME_CNT_W-1:0] frame_cnt_d;
  logic                   proto_err_d, in_ready_d, mm_start_d, mm_valid_d, busy_d;
  logic [DW-1:0]          mm_data_d, rd_data;
  logic                   wr_en;

  assign wr_en = (state == FILL) && in_valid && in_ready;

  // Read one element ahead so mm_data can be registered with no bubble.
  assign rd_addr   = (state == STREAM) ? rptr + 1'b1 : '0;
  assign mm_data_d = mm_valid_d ? rd_data : '0;

  mm_elem_buf #(.DW(DW), .DEPTH(N_ELEM), .AW(AW)) u_buf (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wptr),
    .wr_data (in_data),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  // NOTE: every signal is given a default before the case so no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d     = state;
    wptr_d      = wptr;
    rptr_d      = rptr;
    frame_cnt_d = frame_cnt;
    mm_valid_d  = 1'b0;
    proto_err_d = proto_err | (mm_done && (state != WAIT_DONE));
    case (state)
      FILL: begin
        if (wr_en) begin
          if (wptr == LAST) begin
            wptr_d  = '0;
            state_d = START;
          end else begin
            wptr_d = wptr + 1'b1;
          end
        end
      end
      START: begin
        rptr_d     = '0;
        mm_valid_d = 1'b1;
        state_d    = STREAM;
      end
      STREAM: begin
        if (rptr == LAST) begin
          state_d = WAIT_DONE;
        end else begin
          rptr_d     = rptr + 1'b1;
          mm_valid_d = 1'b1;
        end
      end
      WAIT_DONE: begin
        if (mm_done) begin
          frame_cnt_d = frame_cnt + 1'b1;
          state_d     = FILL;
        end
      end
      default: state_d = FILL;
    endcase
    mm_start_d = (state_d == START);
    in_ready_d = (state_d == FILL);
    busy_d     = (state_d != FILL);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= FILL;
      wptr      <= '0;
      rptr      <= '0;
      frame_cnt <= '0;
      proto_err <= 1'b0;
      in_ready  <= 1'b0;
      mm_start  <= 1'b0;
      mm_valid  <= 1'b0;
      mm_data   <= '0;
      busy      <= 1'b0;
    end else begin
      state     <= state_d;
      wptr      <= wptr_d;
      rptr      <= rptr_d;
      frame_cnt <= frame_cnt_d;
      proto_err <= proto_err_d;
      in_ready  <= in_ready_d;
      mm_start  <= mm_start_d;
      mm_valid  <= mm_valid_d;
      mm_data   <= mm_data_d;
      busy      <= busy_d;
    end
  end

endmodule

// File: tb/tb_mm_input_loader.sv
// Self-checking bench for mm_input_loader (DIM=2): a frame-level reference model
// predicts every output each cycle; literal checks pin the key scenarios.
module tb_mm_input_loader;

  localparam int DW = 8;
  localparam int DIM = 2;
  localparam int N = 2 * DIM * DIM;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [DW-1:0] in_data = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          mm_start;
  logic [DW-1:0] mm_data;
  logic          mm_valid;
  logic          mm_done = 1'b0;
  logic          busy;
  logic [7:0]    frame_cnt;
  logic          proto_err;

  int checks = 0;
  int errors = 0;

  mm_input_loader #(.DW(DW), .DIM(DIM)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mm_start  (mm_start),
    .mm_data   (mm_data),
    .mm_valid  (mm_valid),
    .mm_done   (mm_done),
    .busy      (busy),
    .frame_cnt (frame_cnt),
    .proto_err (proto_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- Reference model ----------------
  // A frame is collected from accepted elements; on completion its whole output
  // schedule (one start cycle, then N data cycles) is queued up front.
  typedef struct packed {
    logic          start;
    logic          valid;
    logic [DW-1:0] data;
  } slot_t;

  slot_t         sched[$];
  logic [DW-1:0] frame[$];
  slot_t         cur = '0;
  logic          m_ready = 1'b0;
  logic          m_holding = 1'b0;
  logic [7:0]    m_cnt = '0;
  logic          m_err = 1'b0;
  logic          done_ok;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      sched.delete();
      frame.delete();
      cur       = '0;
      m_ready   = 1'b0;
      m_holding = 1'b0;
      m_cnt     = '0;
      m_err     = 1'b0;
    end else begin
      done_ok = mm_done && m_holding && !cur.start && !cur.valid;
      if (mm_done && !done_ok) m_err = 1'b1;
      if (in_valid && m_ready) begin
        frame.push_back(in_data);
        if (frame.size() == N) begin
          sched.push_back('{start: 1'b1, valid: 1'b0, data: '0});
          foreach (frame[i]) sched.push_back('{start: 1'b0, valid: 1'b1, data: frame[i]});
          frame.delete();
          m_holding = 1'b1;
        end
      end
      if (done_ok) begin
        m_cnt++;
        m_holding = 1'b0;
      end
      m_ready = !m_holding;
      cur = (sched.size() > 0) ? sched.pop_front() : slot_t'('0);
    end
  end

  // ---------------- Compare process and burst monitor ----------------
  logic [DW-1:0] seen_q[$];
  int            start_cnt = 0;

  always @(negedge clk) begin
    check("in_ready", in_ready, m_ready);
    check("busy", busy, m_holding);
    check("mm_start", mm_start, cur.start);
    check("mm_valid", mm_valid, cur.valid);
    check("mm_data", mm_data, cur.valid ? cur.data : '0);
    check("frame_cnt", frame_cnt, m_cnt);
    check("proto_err", proto_err, m_err);
    if (mm_valid) seen_q.push_back(mm_data);
    if (mm_start) start_cnt++;
  end

  // ---------------- Stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic timeout(input string what);
    checks++;
    errors++;
    $display("FAIL timeout %s at %0t", what, $time);
  endtask

  // gap_mode: 0 back-to-back, 1 one idle cycle after each element, 2 random 0..2
  task automatic send_frame(input logic [7:0] base, input bit rnd, input int gap_mode, input bit bp);
    for (int i = 0; i < N; i++) begin
      int  n;
      bit  hs;
      int  gap;
      in_valid = 1'b1;
      in_data  = rnd ? 8'($urandom) : 8'(base + i);
      n = 0;
      hs = 1'b0;
      while (!hs && n < 100) begin
        hs = in_ready;
        tick();
        n++;
      end
      if (!hs) timeout("input handshake");
      in_valid = 1'b0;
      gap = (gap_mode == 1) ? 1 : (gap_mode == 2) ? int'($urandom_range(0, 2)) : 0;
      if (i != N - 1) repeat (gap) tick();
    end
    if (bp) begin
      in_valid = 1'b1;
      in_data  = 8'hFF;
    end
  endtask

  task automatic wait_for_wait_done();
    int n = 0;
    while (!(busy && !mm_start && !mm_valid) && n < 100) begin
      tick();
      n++;
    end
    if (n >= 100) timeout("stream end");
  endtask

  task automatic pulse_done();
    mm_done = 1'b1;
    tick();
    mm_done = 1'b0;
  endtask

  task automatic check_burst(input string name, input logic [7:0] base);
    check({name, "_len"}, seen_q.size(), N);
    for (int i = 0; i < N; i++)
      if (i < seen_q.size()) check({name, "_elem"}, seen_q[i], 8'(base + i));
    check({name, "_starts"}, start_cnt, 1);
  endtask

  task automatic clear_mon();
    seen_q.delete();
    start_cnt = 0;
  endtask

  // ---------------- Scenarios ----------------
  initial begin
    #2 reset = 1'b0;
    #20 reset = 1'b1;
    tick();
    check("post_reset_ready", in_ready, 1);
    check("post_reset_busy", busy, 0);

    // Basic frame
    clear_mon();
    send_frame(8'h01, 1'b0, 0, 1'b0);
    check("basic_start_now", mm_start, 1);
    wait_for_wait_done();
    repeat (3) tick();
    pulse_done();
    check("basic_cnt", frame_cnt, 1);
    check("basic_ready", in_ready, 1);
    check_burst("basic", 8'h01);

    // Gapped input
    clear_mon();
    send_frame(8'hA0, 1'b0, 1, 1'b0);
    wait_for_wait_done();
    pulse_done();
    check("gap_cnt", frame_cnt, 2);
    check_burst("gap", 8'hA0);

    // Backpressure through STREAM and WAIT_DONE
    clear_mon();
    send_frame(8'h00, 1'b1, 0, 1'b1);
    wait_for_wait_done();
    repeat (4) tick();
    check("bp_ready_low", in_ready, 0);
    in_valid = 1'b0;
    pulse_done();
    clear_mon();
    send_frame(8'h31, 1'b0, 0, 1'b0);
    wait_for_wait_done();
    pulse_done();
    check("bp_cnt", frame_cnt, 4);
    check_burst("bp_next", 8'h31);

    // Early done during STREAM
    clear_mon();
    send_frame(8'h00, 1'b1, 2, 1'b0);
    repeat (4) tick();
    check("early_in_stream", mm_valid, 1);
    pulse_done();
    check("early_err", proto_err, 1);
    wait_for_wait_done();
    repeat (3) tick();
    check("early_still_busy", busy, 1);
    check("early_len", seen_q.size(), N);
    pulse_done();
    check("early_cnt", frame_cnt, 5);
    check("early_err_sticky", proto_err, 1);

    // Reset mid-stream
    clear_mon();
    send_frame(8'h00, 1'b1, 0, 1'b0);
    repeat (4) tick();
    #2 reset = 1'b0;
    #1;
    check("rst_valid", mm_valid, 0);
    check("rst_data", mm_data, 0);
    check("rst_start", mm_start, 0);
    check("rst_ready", in_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_cnt", frame_cnt, 0);
    check("rst_err", proto_err, 0);
    @(negedge clk);
    #2 reset = 1'b1;
    tick();
    check("rst_release_ready", in_ready, 1);
    clear_mon();
    send_frame(8'h11, 1'b0, 0, 1'b0);
    wait_for_wait_done();
    pulse_done();
    check("rst_cnt_after", frame_cnt, 1);
    check_burst("rst_frame", 8'h11);

    // Counter wrap
    for (int f = 0; f < 256; f++) begin
      send_frame(8'h00, 1'b1, 2, 1'b0);
      wait_for_wait_done();
      repeat ($urandom_range(0, 2)) tick();
      pulse_done();
      if (f == 253) check("wrap_255", frame_cnt, 8'd255);
      if (f == 254) check("wrap_0", frame_cnt, 8'd0);
    end
    check("wrap_final", frame_cnt, 8'd1);

    repeat (2) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mm_input_loader.md
# mm_input_loader

Front-end stage that feeds the byte-serial matrix multiplier. Accepts one operand frame (matrix A then matrix B, row-major, `2*DIM*DIM` elements) from an upstream valid/ready source and buffers it locally. Once the frame is complete, it pulses the multiplier's start and streams the frame on consecutive cycles. It then holds off new input until the multiplier reports done.

## Interface
Parameters:
- `DW`, 8: element width in bits.
- `DIM`, 4: square matrix dimension.
- `N_ELEM` (localparam), `2*DIM*DIM`: elements per frame.
- `AW` (localparam), `$clog2(N_ELEM)`: buffer pointer width.

Ports:
- `clk`, input, 1: single clock; all logic on the rising edge.
- `reset`, input, 1: reset, asynchronous, active-low.
- `in_data`, input, DW: upstream element.
- `in_valid`, input, 1: upstream element valid.
- `in_ready`, output, 1: loader can accept an element (registered).
- `mm_start`, output, 1: one-cycle start pulse to the multiplier.
- `mm_data`, output, DW: element to the multiplier's `data_in`.
- `mm_valid`, output, 1: `mm_data` carries a frame element.
- `mm_done`, input, 1: multiplier completion.
- `busy`, output, 1: high in every state except FILL.
- `frame_cnt`, output, 8: completed frames; wraps 255→0.
- `proto_err`, output, 1: sticky; set when `mm_done` arrives outside WAIT_DONE.

## Operation
States are FILL, START, STREAM and WAIT_DONE.
- **FILL**
  - On `in_valid && in_ready`: write `buf[wptr] <= in_data` and increment `wptr`.
  - On the handshake with `wptr == N_ELEM-1`: `wptr` returns to 0, `in_ready` drops at the next edge, and the state goes to START.
  - `in_valid` with `in_ready` low is ignored; the upstream source must hold the element.
- **START**
  - `mm_start=1` for exactly one cycle.
  - `rptr=0`, then go to STREAM.
- **STREAM**
  - `mm_valid=1` and `mm_data=buf[rptr]`; `rptr` increments every cycle with no stalls.
  - After `rptr == N_ELEM-1`, go to WAIT_DONE.
- **WAIT_DONE**
  - Outputs idle. On `mm_done=1`: increment `frame_cnt`, go to FILL, and set `in_ready` to 1 at the same edge.
- **Outputs outside STREAM/START**
  - `mm_data` is 0 whenever `mm_valid=0`.
  - `mm_start` is 0 outside START.
- **Protocol error**
  - `mm_done` in FILL, START or STREAM is ignored for sequencing and sets `proto_err`.
  - `proto_err` clears only on reset.
- **Reset** (asynchronous, any time, including mid-STREAM)
  - State returns to FILL; `wptr`, `rptr`, `frame_cnt` and `proto_err` clear to 0.
  - `in_ready=0`, `mm_start=0`, `mm_valid=0`, `mm_data=0`, `busy=0`.
  - Buffer contents are don't-care and are not cleared.
  - `in_ready` rises on the first rising edge after reset deasserts.
- **Data path**
  - Elements pass through unmodified; there is no width conversion.
  - Element order on `mm_data` equals arrival order.

## Timing
- Last input handshake at edge T → `mm_start` high in cycle T+1.
- Elements 0..N_ELEM-1 appear on cycles T+2 … T+1+N_ELEM with `mm_valid` high.
- `mm_done` sampled high at edge D → `in_ready=1` from D+1 onward. The earliest next handshake is edge D+1.
- Throughput: at most one element per cycle in each direction.
- All outputs are registered. `in_ready` is never combinationally dependent on `in_valid`.

## Structure
- Shared package `mm_pkg` holds:
  - the state enum `mm_ld_state_t` (FILL, START, STREAM, WAIT_DONE);
  - the default `DW`;
  - the `FRAME_CNT_W = 8` constant.
- Sub-module `mm_elem_buf`: `N_ELEM x DW` register array with one synchronous write port and one combinational read port. It has no reset.
- The FSM, pointers and counters sit in `mm_input_loader`.

## Test plan
All scenarios use DIM=2, N_ELEM=8.
- **Basic frame.** Send 8 back-to-back elements 0x01..0x08 with `in_valid` held high, then `mm_done` 3 cycles after the last element.
  - `mm_start` is high exactly 1 cycle, one cycle after the 8th handshake.
  - `mm_data` shows 0x01..0x08 on 8 consecutive `mm_valid` cycles.
  - `frame_cnt` goes 0→1 and `in_ready` is back to 1.
- **Gapped input.** Toggle `in_valid` every other cycle, data 0xA0..0xA7.
  - The same 8-cycle burst as above occurs, with no gaps or duplicates in it.
- **Backpressure.** Hold `in_valid=1` with data 0xFF throughout STREAM and WAIT_DONE.
  - `in_ready` stays 0 and no write occurs.
  - The next frame starts from `wptr=0` after `mm_done`.
- **Early done.** Assert `mm_done` in cycle 4 of STREAM.
  - The stream still completes all 8 elements and `proto_err` is 1.
  - The loader still waits for a second `mm_done` before returning to FILL.
- **Reset mid-stream.** Drive `reset` low during element 3 of STREAM.
  - All outputs go to their reset values immediately.
  - After release, `in_ready=1` on the next edge, and a fresh frame of 0x11..0x18 streams correctly.
- **Counter wrap.** Run 256 frames.
  - `frame_cnt` wraps 255→0 and streaming is unaffected.
